// File: rtl/loader_pkg.sv
// Shared definitions for the program loader.
//   state_t          : load FSM states
//   WORD_W / BYTE_W  : instruction word and stream byte widths
//   takes_bytes()    : true in the states that consume stream bytes
package loader_pkg;

    localparam int WORD_W = 16;
    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        CSUM,
        DONE,
        ERR
    } state_t;

    function automatic logic takes_bytes(input state_t s);
        return (s == LEN) || (s == DATA) || (s == CSUM);
    endfunction

endpackage

// File: rtl/byte_to_word_assembler.sv
// Little-endian byte-pair to 16-bit word assembler.
//   clk, reset_n : clock, asynchronous active-low reset
//   clear        : force the next accepted byte to be a low byte
//   byte_valid   : a byte transfers this cycle
//   byte_data    : the byte
//   word_valid   : combinational pulse in the cycle the high byte transfers
//   word         : assembled word, meaningful while word_valid is high
//   phase        : 0 = expecting low byte, 1 = expecting high byte
module byte_to_word_assembler
    import loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              byte_valid,
    input  logic [BYTE_W-1:0] byte_data,
    output logic              word_valid,
    output logic [WORD_W-1:0] word,
    output logic              phase
);

    logic [BYTE_W-1:0] low_byte;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase    <= 1'b0;
            low_byte <= '0;
        end else if (clear) begin
            phase <= 1'b0;
        end else if (byte_valid) begin
            phase <= ~phase;
            if (!phase) begin
                low_byte <= byte_data;
            end
        end
    end

    // The high byte is passed straight through so the word is usable in
    // the same cycle it completes.
    assign word_valid = byte_valid & phase;
    assign word       = {byte_data, low_byte};

endmodule

// File: rtl/program_loader.sv
// Host-side loader for the fetch unit's instruction-memory write port.
// Accepts a framed byte stream (LEN word, LEN data words, XOR checksum word),
// writes each data word into fetch memory and keeps the fetch unit and core
// in reset until a load completes with a matching checksum.
//   clk, reset_n            : clock, asynchronous active-low reset
//   start                   : one-cycle pulse, begins a load when not busy
//   in_data/in_valid/ready  : byte stream, one byte per cycle when ready
//   write_enable_fm/_data_fm/_addr_fm : fetch-memory write port
//   rst_fm, core_reset      : active-high resets, released only after success
//   busy, done, error       : load status
//   words_loaded            : data words written in the current/last load
module program_loader
    import loader_pkg::*;
#(
    parameter int                 ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]  BASE_ADDR = '0,
    parameter int unsigned        MAX_WORDS = 1024
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [BYTE_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              write_enable_fm,
    output logic [WORD_W-1:0] write_data_fm,
    output logic [ADDR_W-1:0] write_addr_fm,
    output logic              rst_fm,
    output logic              core_reset,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [15:0]       words_loaded
);

    state_t              state;
    state_t              state_next;
    logic                byte_fire;
    logic                load_start;
    logic                word_valid;
    logic [WORD_W-1:0]   word;
    logic                asm_phase;
    logic [WORD_W-1:0]   n_words;
    logic [WORD_W-1:0]   xor_acc;
    logic                len_too_big;
    logic                last_word;

    assign byte_fire   = in_valid & in_ready;
    // start is only honoured between loads; a pulse while busy is dropped.
    assign load_start  = start & ~takes_bytes(state);
    assign len_too_big = 32'(word) > MAX_WORDS;
    assign last_word   = (words_loaded == n_words - 16'd1);

    byte_to_word_assembler u_asm (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (load_start),
        .byte_valid (byte_fire),
        .byte_data  (in_data),
        .word_valid (word_valid),
        .word       (word),
        .phase      (asm_phase)
    );

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE, DONE, ERR: begin
                if (start) state_next = LEN;
            end
            LEN: begin
                if (word_valid) begin
                    if (len_too_big)        state_next = ERR;
                    else if (word == '0)    state_next = CSUM;
                    else                    state_next = DATA;
                end
            end
            DATA: begin
                if (word_valid && last_word) state_next = CSUM;
            end
            CSUM: begin
                if (word_valid) state_next = (word == xor_acc) ? DONE : ERR;
            end
            default: state_next = IDLE;
        endcase
    end

    // Status outputs are decoded from the registered state, so releasing
    // the resets happens exactly one cycle after the checksum word completes.
    always_comb begin
        in_ready   = takes_bytes(state);
        busy       = takes_bytes(state);
        done       = (state == DONE);
        error      = (state == ERR);
        rst_fm     = (state != DONE);
        core_reset = (state != DONE);
    end

    // Write port, word counter and running checksum
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            write_enable_fm <= 1'b0;
            write_data_fm   <= '0;
            write_addr_fm   <= '0;
            words_loaded    <= '0;
            n_words         <= '0;
            xor_acc         <= '0;
        end else begin
            write_enable_fm <= 1'b0;
            if (load_start) begin
                words_loaded <= '0;
                xor_acc      <= '0;
            end
            if (state == LEN && word_valid) begin
                n_words      <= word;
                words_loaded <= '0;
                xor_acc      <= '0;
            end
            // The last strobe lands in the first CSUM cycle, overlapping
            // acceptance of the checksum bytes.
            if (state == DATA && word_valid) begin
                write_enable_fm <= 1'b1;
                write_data_fm   <= word;
                write_addr_fm   <= BASE_ADDR + ADDR_W'(words_loaded);
                words_loaded    <= words_loaded + 16'd1;
                xor_acc         <= xor_acc ^ word;
            end
        end
    end

    // Every terminal state is entered on a completed word, so the
    // assembler must be waiting for a low byte there.
    a_phase_aligned : assert property (@(posedge clk) disable iff (!reset_n)
        (state == DONE || state == ERR) |-> !asm_phase);

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

    localparam int S_IDLE = 0;
    localparam int S_BUSY = 1;
    localparam int S_DONE = 2;
    localparam int S_ERR  = 3;

    typedef struct {
        logic        st;
        logic        vl;
        logic [7:0]  dt;
        logic        we;
        logic [15:0] wd;
        logic [31:0] wa;
        logic        bs;
        logic        dn;
        logic        er;
        logic        rn;
        logic        rd;
        logic [15:0] wl;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;

    logic        rdy0, we0, rfm0, cr0, busy0, done0, err0;
    logic [15:0] wd0, wl0;
    logic [31:0] wa0;
    logic        rdy1, we1, rfm1, cr1, busy1, done1, err1;
    logic [15:0] wd1, wl1;
    logic [31:0] wa1;

    int n_checks = 0;
    int n_fail   = 0;
    int bad_we   = 0;
    logic cap_en = 1'b0;
    logic [47:0] cap0[$];
    logic [47:0] cap1[$];
    vec_t vecs[$];

    logic [7:0] frame_ok  [10] = '{8'h03, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A, 8'hF0, 8'hDE};
    logic [7:0] frame_gap [10] = '{8'h03, 8'h00, 8'hB2, 8'hA1, 8'hD4, 8'hC3, 8'h1E, 8'h0F, 8'h78, 8'h6D};
    logic [15:0] gap_words [3] = '{16'hA1B2, 16'hC3D4, 16'h0F1E};
    logic [15:0] ok_words  [3] = '{16'h1234, 16'h5678, 16'h9ABC};

    always #5 clk = ~clk;

    program_loader #(.ADDR_W(32), .BASE_ADDR(32'h0), .MAX_WORDS(1024)) u0 (
        .clk(clk), .reset_n(reset_n), .start(start), .in_data(in_data),
        .in_valid(in_valid), .in_ready(rdy0), .write_enable_fm(we0),
        .write_data_fm(wd0), .write_addr_fm(wa0), .rst_fm(rfm0),
        .core_reset(cr0), .busy(busy0), .done(done0), .error(err0),
        .words_loaded(wl0)
    );

    program_loader #(.ADDR_W(32), .BASE_ADDR(32'h100), .MAX_WORDS(1024)) u1 (
        .clk(clk), .reset_n(reset_n), .start(start), .in_data(in_data),
        .in_valid(in_valid), .in_ready(rdy1), .write_enable_fm(we1),
        .write_data_fm(wd1), .write_addr_fm(wa1), .rst_fm(rfm1),
        .core_reset(cr1), .busy(busy1), .done(done1), .error(err1),
        .words_loaded(wl1)
    );

    // A strobe outside a load (other than during reset, where it must be low)
    // is always an error; the trailing strobe falls in CSUM where busy=1.
    always @(negedge clk) begin
        if (we0 && (!busy0 || !reset_n)) bad_we++;
        if (cap_en && we0) cap0.push_back({wa0, wd0});
        if (cap_en && we1) cap1.push_back({wa1, wd1});
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void add(input int st, input int vl, input int dt, input int we,
                                input int wd, input int wa, input int stat, input int wl);
        vec_t v;
        v.st = 1'(st);  v.vl = 1'(vl);  v.dt = 8'(dt);
        v.we = 1'(we);  v.wd = 16'(wd); v.wa = 32'(wa);
        v.wl = 16'(wl);
        v.bs = (stat == S_BUSY);
        v.rd = (stat == S_BUSY);
        v.dn = (stat == S_DONE);
        v.er = (stat == S_ERR);
        v.rn = (stat == S_DONE);
        vecs.push_back(v);
    endfunction

    // Length 3 and the three data words, with one idle gap inside word 0.
    function automatic void add_data_rows();
        add(0, 1, 'h03, 0, 0,       0, S_BUSY, 0);
        add(0, 1, 'h00, 0, 0,       0, S_BUSY, 0);
        add(0, 1, 'h34, 0, 0,       0, S_BUSY, 0);
        add(0, 0, 'hEE, 0, 0,       0, S_BUSY, 0);
        add(0, 1, 'h12, 1, 'h1234,  0, S_BUSY, 1);
        add(0, 1, 'h78, 0, 0,       0, S_BUSY, 1);
        add(0, 1, 'h56, 1, 'h5678,  1, S_BUSY, 2);
        add(0, 1, 'hBC, 0, 0,       0, S_BUSY, 2);
        add(0, 1, 'h9A, 1, 'h9ABC,  2, S_BUSY, 3);
    endfunction

    task automatic send_frame_ok();
        @(negedge clk);
        start = 1'b1; in_valid = 1'b0;
        for (int b = 0; b < 10; b++) begin
            @(negedge clk);
            start = 1'b0; in_valid = 1'b1; in_data = frame_ok[b];
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (2) @(negedge clk);

        // Reset values
        check("rst_in_ready", 32'(rdy0), 0);
        check("rst_we",       32'(we0),  0);
        check("rst_wdata",    32'(wd0),  0);
        check("rst_waddr",    wa0,       0);
        check("rst_rst_fm",   32'(rfm0), 1);
        check("rst_core",     32'(cr0),  1);
        check("rst_busy",     32'(busy0), 0);
        check("rst_done",     32'(done0), 0);
        check("rst_error",    32'(err0), 0);
        check("rst_words",    32'(wl0),  0);
        reset_n = 1'b1;

        // Table: good frame, bad checksum, oversize length, empty frame
        add(0, 1, 'h03, 0, 0, 0, S_IDLE, 0);
        add(1, 0, 0,    0, 0, 0, S_BUSY, 0);
        add_data_rows();
        add(0, 1, 'hF0, 0, 0, 0, S_BUSY, 3);
        add(0, 1, 'hDE, 0, 0, 0, S_DONE, 3);
        add(0, 1, 'h55, 0, 0, 0, S_DONE, 3);

        add(1, 0, 0,    0, 0, 0, S_BUSY, 0);
        add_data_rows();
        add(0, 1, 'h00, 0, 0, 0, S_BUSY, 3);
        add(0, 1, 'h00, 0, 0, 0, S_ERR,  3);
        add(0, 0, 0,    0, 0, 0, S_ERR,  3);

        add(1, 0, 0,    0, 0, 0, S_BUSY, 0);
        add(0, 1, 'h01, 0, 0, 0, S_BUSY, 0);
        add(0, 1, 'h04, 0, 0, 0, S_ERR,  0);
        add(0, 1, 'hAA, 0, 0, 0, S_ERR,  0);

        add(1, 0, 0,    0, 0, 0, S_BUSY, 0);
        add(0, 1, 'h00, 0, 0, 0, S_BUSY, 0);
        add(0, 1, 'h00, 0, 0, 0, S_BUSY, 0);
        add(0, 1, 'h00, 0, 0, 0, S_BUSY, 0);
        add(0, 1, 'h00, 0, 0, 0, S_DONE, 0);

        foreach (vecs[i]) begin
            @(negedge clk);
            start = vecs[i].st; in_valid = vecs[i].vl; in_data = vecs[i].dt;
            @(posedge clk);
            #1;
            check($sformatf("v%0d_we", i), 32'(we0), 32'(vecs[i].we));
            if (vecs[i].we) begin
                check($sformatf("v%0d_wdata", i), 32'(wd0), 32'(vecs[i].wd));
                check($sformatf("v%0d_waddr", i), wa0, vecs[i].wa);
            end
            check($sformatf("v%0d_busy", i),     32'(busy0), 32'(vecs[i].bs));
            check($sformatf("v%0d_done", i),     32'(done0), 32'(vecs[i].dn));
            check($sformatf("v%0d_error", i),    32'(err0),  32'(vecs[i].er));
            check($sformatf("v%0d_rst_fm", i),   32'(rfm0),  32'(!vecs[i].rn));
            check($sformatf("v%0d_core_rst", i), 32'(cr0),   32'(!vecs[i].rn));
            check($sformatf("v%0d_in_ready", i), 32'(rdy0),  32'(vecs[i].rd));
            check($sformatf("v%0d_words", i),    32'(wl0),   32'(vecs[i].wl));
        end
        @(negedge clk);
        start = 1'b0; in_valid = 1'b0;

        // Random gaps, BASE_ADDR=0x100, start pulsed mid-load
        cap1.delete();
        cap_en = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int b = 0; b < 10; b++) begin
            int   tries;
            logic xfer;
            tries = 0;
            xfer  = 1'b0;
            while (!xfer && tries < 20) begin
                if (tries > 0) @(negedge clk);
                start    = (b == 5 && tries == 0);
                in_valid = (tries >= 6) ? 1'b1 : 1'($urandom_range(0, 1));
                in_data  = in_valid ? frame_gap[b] : 8'hEE;
                xfer     = in_valid && rdy1;
                tries++;
            end
            if (!xfer) begin
                check($sformatf("gap_stall_b%0d", b), 32'(rdy1), 1);
                break;
            end
            @(negedge clk);
            start = 1'b0; in_valid = 1'b0;
        end
        @(negedge clk);
        check("gap_done",  32'(done1), 1);
        check("gap_error", 32'(err1),  0);
        check("gap_busy",  32'(busy1), 0);
        check("gap_words", 32'(wl1),   3);
        check("gap_nwrites", 32'(cap1.size()), 3);
        for (int k = 0; k < 3 && k < cap1.size(); k++) begin
            check($sformatf("gap_addr%0d", k), cap1[k][47:16], 32'h100 + 32'(k));
            check($sformatf("gap_data%0d", k), 32'(cap1[k][15:0]), 32'(gap_words[k]));
        end
        cap_en = 1'b0;

        // Asynchronous reset after the second data word
        @(negedge clk);
        start = 1'b1;
        for (int b = 0; b < 6; b++) begin
            @(negedge clk);
            start = 1'b0; in_valid = 1'b1; in_data = frame_ok[b];
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("abort_pending_we", 32'(we0), 1);
        #1 reset_n = 1'b0;
        #1;
        check("abort_we",       32'(we0),  0);
        check("abort_wdata",    32'(wd0),  0);
        check("abort_waddr",    wa0,       0);
        check("abort_rst_fm",   32'(rfm0), 1);
        check("abort_core",     32'(cr0),  1);
        check("abort_busy",     32'(busy0), 0);
        check("abort_in_ready", 32'(rdy0), 0);
        check("abort_words",    32'(wl0),  0);
        cap0.delete();
        cap_en = 1'b1;
        repeat (3) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = 8'h5A;
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("abort_no_writes", 32'(cap0.size()), 0);
        reset_n = 1'b1;
        @(negedge clk);
        check("abort_idle_busy", 32'(busy0), 0);

        send_frame_ok();
        check("reload_done",    32'(done0), 1);
        check("reload_core",    32'(cr0),   0);
        check("reload_words",   32'(wl0),   3);
        check("reload_nwrites", 32'(cap0.size()), 3);
        for (int k = 0; k < 3 && k < cap0.size(); k++) begin
            check($sformatf("reload_addr%0d", k), cap0[k][47:16], 32'(k));
            check($sformatf("reload_data%0d", k), 32'(cap0[k][15:0]), 32'(ok_words[k]));
        end
        cap_en = 1'b0;

        check("stray_strobes", 32'(bad_we), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
